// File: rtl/deser_align_ctrl_if.sv
// Receive-side bundle for the word aligner: serial data/K-flag bits in,
// aligned parallel words and link status out.
interface deser_align_ctrl_if #(
   parameter int BITS = 8
) ();
   logic            data;
   logic            DK;
   logic [BITS-1:0] out;
   logic [BITS-1:0] out_DK;
   logic            word_valid;
   logic            sync;
   logic [1:0]      state;

   modport master (
      output data, DK,
      input  out, out_DK, word_valid, sync, state
   );

   modport slave (
      input  data, DK,
      output out, out_DK, word_valid, sync, state
   );
endinterface

// File: rtl/deser_align_ctrl.sv
// Comma-based word aligner and link-sync FSM for the serial receive path.
// Locks after LOCK_CNT aligned commas, drops after LOSS_CNT misaligned commas.
module deser_align_ctrl #(
   parameter int              BITS     = 8,
   parameter logic [BITS-1:0] COMMA    = 8'hBC,
   parameter int              LOCK_CNT = 3,
   parameter int              LOSS_CNT = 4
) (
   input logic               clk,
   input logic               reset,
   deser_align_ctrl_if.slave bus
);
   localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
   localparam int LW = $clog2(LOCK_CNT + 1);
   localparam int EW = $clog2(LOSS_CNT + 1);

   typedef enum logic [1:0] {
      ST_LOS  = 2'd0,
      ST_ACQ  = 2'd1,
      ST_SYNC = 2'd2
   } state_t;

   state_t          state_r;
   logic [BITS-1:0] dsh_r;
   logic [BITS-1:0] ksh_r;
   logic [CW-1:0]   bit_cnt_r;
   logic [LW-1:0]   comma_cnt_r;
   logic [EW-1:0]   err_cnt_r;
   logic [BITS-1:0] out_r;
   logic [BITS-1:0] out_dk_r;
   logic            word_valid_r;
   logic            sync_r;

   logic [BITS-1:0] cand_s;
   logic [BITS-1:0] candk_s;
   logic            is_comma_s;
   logic            boundary_s;

   // A K-word needs every DK bit set; the data pattern alone is not enough.
   function automatic logic comma_match(input logic [BITS-1:0] d, input logic [BITS-1:0] k);
      return (d == COMMA) && (k == {BITS{1'b1}});
   endfunction

   // Candidate word includes the bit arriving on the current edge.
   always_comb begin
      cand_s     = {dsh_r[BITS-2:0], bus.data};
      candk_s    = {ksh_r[BITS-2:0], bus.DK};
      is_comma_s = comma_match(cand_s, candk_s);
      boundary_s = (bit_cnt_r == CW'(BITS - 1));
   end

   // Alignment FSM, counters, shift registers and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_LOS;
         dsh_r        <= '0;
         ksh_r        <= '0;
         bit_cnt_r    <= '0;
         comma_cnt_r  <= '0;
         err_cnt_r    <= '0;
         out_r        <= '0;
         out_dk_r     <= '0;
         word_valid_r <= 1'b0;
         sync_r       <= 1'b0;
      end else begin
         dsh_r        <= cand_s;
         ksh_r        <= candk_s;
         word_valid_r <= 1'b0;
         bit_cnt_r    <= boundary_s ? '0 : bit_cnt_r + CW'(1);

         case (state_r)
            ST_LOS: begin
               if (is_comma_s) begin
                  bit_cnt_r   <= '0;
                  comma_cnt_r <= LW'(1);
                  state_r     <= ST_ACQ;
               end else begin
                  comma_cnt_r <= '0;
               end
            end

            ST_ACQ: begin
               if (boundary_s && is_comma_s) begin
                  if (comma_cnt_r + LW'(1) >= LW'(LOCK_CNT)) begin
                     comma_cnt_r <= LW'(LOCK_CNT);
                     err_cnt_r   <= '0;
                     state_r     <= ST_SYNC;
                     sync_r      <= 1'b1;
                  end else begin
                     comma_cnt_r <= comma_cnt_r + LW'(1);
                  end
               end else if (boundary_s) begin
                  comma_cnt_r <= '0;
                  state_r     <= ST_LOS;
               end else begin
                  comma_cnt_r <= comma_cnt_r;
               end
            end

            ST_SYNC: begin
               if (boundary_s) begin
                  out_r        <= cand_s;
                  out_dk_r     <= candk_s;
                  word_valid_r <= 1'b1;
                  if (is_comma_s) begin
                     err_cnt_r <= '0;
                  end else begin
                     err_cnt_r <= err_cnt_r;
                  end
               end else if (is_comma_s) begin
                  // bit_cnt keeps running; the next comma seen in LOS realigns.
                  if (err_cnt_r + EW'(1) >= EW'(LOSS_CNT)) begin
                     err_cnt_r <= EW'(LOSS_CNT);
                     state_r   <= ST_LOS;
                     sync_r    <= 1'b0;
                  end else begin
                     err_cnt_r <= err_cnt_r + EW'(1);
                  end
               end else begin
                  err_cnt_r <= err_cnt_r;
               end
            end

            default: begin
               state_r     <= ST_LOS;
               sync_r      <= 1'b0;
               comma_cnt_r <= '0;
               err_cnt_r   <= '0;
            end
         endcase
      end
   end

   assign bus.out        = out_r;
   assign bus.out_DK     = out_dk_r;
   assign bus.word_valid = word_valid_r;
   assign bus.sync       = sync_r;
   assign bus.state      = state_r;
endmodule

// File: tb/tb_deser_align_ctrl.sv
// Directed bench for deser_align_ctrl: table of framed words with expected
// status/outputs, plus hand sequences for asynchronous reset.
module tb_deser_align_ctrl;
   logic clk;
   logic reset;
   int   n_run;
   int   n_fail;

   deser_align_ctrl_if #(.BITS(8)) bus ();

   deser_align_ctrl #(
      .BITS(8), .COMMA(8'hBC), .LOCK_CNT(3), .LOSS_CNT(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         pre;   // zero filler bits (DK=0) before the word
      logic [7:0] d;
      logic [7:0] k;
      logic [1:0] st;
      logic       sy;
      logic       wv;
      logic [7:0] o;
      logic [7:0] ok;
   } vec_t;

   vec_t tbl[25];

   task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec%0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic send_bit(input logic d, input logic k);
      @(negedge clk);
      bus.data = d;
      bus.DK   = k;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [7:0] d, input logic [7:0] k);
      for (int b = 7; b >= 0; b--) send_bit(d[b], k[b]);
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         for (int p = 0; p < tbl[i].pre; p++) send_bit(1'b0, 1'b0);
         send_word(tbl[i].d, tbl[i].k);
         chk("state", i, {6'd0, bus.state}, {6'd0, tbl[i].st});
         chk("sync", i, {7'd0, bus.sync}, {7'd0, tbl[i].sy});
         chk("word_valid", i, {7'd0, bus.word_valid}, {7'd0, tbl[i].wv});
         chk("out", i, bus.out, tbl[i].o);
         chk("out_DK", i, bus.out_DK, tbl[i].ok);
      end
   endtask

   task automatic chk_reset_state(input string name);
      chk({name, "_state"}, 0, {6'd0, bus.state}, 8'h00);
      chk({name, "_sync"}, 0, {7'd0, bus.sync}, 8'h00);
      chk({name, "_wv"}, 0, {7'd0, bus.word_valid}, 8'h00);
      chk({name, "_out"}, 0, bus.out, 8'h00);
      chk({name, "_outdk"}, 0, bus.out_DK, 8'h00);
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      // broken acquire: two commas then an aligned data word
      tbl[0]  = '{0, 8'hBC, 8'hFF, 2'd1, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[1]  = '{0, 8'hBC, 8'hFF, 2'd1, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[2]  = '{0, 8'h33, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00};
      // lock at 1-bit offset, then data
      tbl[3]  = '{1, 8'hBC, 8'hFF, 2'd1, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[4]  = '{0, 8'hBC, 8'hFF, 2'd1, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[5]  = '{0, 8'hBC, 8'hFF, 2'd2, 1'b1, 1'b0, 8'h00, 8'h00};
      tbl[6]  = '{0, 8'h5A, 8'h00, 2'd2, 1'b1, 1'b1, 8'h5A, 8'h00};
      tbl[7]  = '{0, 8'hA5, 8'h00, 2'd2, 1'b1, 1'b1, 8'hA5, 8'h00};
      // 3 commas shifted by 3 bits, then an aligned comma clears the error count
      tbl[8]  = '{3, 8'hBC, 8'hFF, 2'd2, 1'b1, 1'b0, 8'h17, 8'h1F};
      tbl[9]  = '{0, 8'hBC, 8'hFF, 2'd2, 1'b1, 1'b0, 8'h97, 8'hFF};
      tbl[10] = '{0, 8'hBC, 8'hFF, 2'd2, 1'b1, 1'b0, 8'h97, 8'hFF};
      tbl[11] = '{5, 8'hBC, 8'hFF, 2'd2, 1'b1, 1'b1, 8'hBC, 8'hFF};
      // 4 misaligned commas: sync held through 3, dropped on the 4th
      tbl[12] = '{3, 8'hBC, 8'hFF, 2'd2, 1'b1, 1'b0, 8'h17, 8'h1F};
      tbl[13] = '{0, 8'hBC, 8'hFF, 2'd2, 1'b1, 1'b0, 8'h97, 8'hFF};
      tbl[14] = '{0, 8'hBC, 8'hFF, 2'd2, 1'b1, 1'b0, 8'h97, 8'hFF};
      tbl[15] = '{0, 8'hBC, 8'hFF, 2'd0, 1'b0, 1'b0, 8'h97, 8'hFF};
      // realign at a new offset, outputs held until new words arrive
      tbl[16] = '{5, 8'hBC, 8'hFF, 2'd1, 1'b0, 1'b0, 8'h97, 8'hFF};
      tbl[17] = '{0, 8'hBC, 8'hFF, 2'd1, 1'b0, 1'b0, 8'h97, 8'hFF};
      tbl[18] = '{0, 8'hBC, 8'hFF, 2'd2, 1'b1, 1'b0, 8'h97, 8'hFF};
      tbl[19] = '{0, 8'hC3, 8'h00, 2'd2, 1'b1, 1'b1, 8'hC3, 8'h00};
      tbl[20] = '{0, 8'h3C, 8'h00, 2'd2, 1'b1, 1'b1, 8'h3C, 8'h00};
      // full relock after reset in SYNC
      tbl[21] = '{2, 8'hBC, 8'hFF, 2'd1, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[22] = '{0, 8'hBC, 8'hFF, 2'd1, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[23] = '{0, 8'hBC, 8'hFF, 2'd2, 1'b1, 1'b0, 8'h00, 8'h00};
      tbl[24] = '{0, 8'h5A, 8'h00, 2'd2, 1'b1, 1'b1, 8'h5A, 8'h00};

      bus.data = 1'b0;
      bus.DK   = 1'b0;
      reset    = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // reset mid-stream after acquisition has started
      send_word(8'hBC, 8'hFF);
      chk("pre_reset_state", 0, {6'd0, bus.state}, 8'h01);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      #2 reset = 1'b1;
      #1 chk_reset_state("t1");
      @(negedge clk);
      reset = 1'b0;

      run_vecs(0, 20);

      // reset between word bits while in SYNC
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      #2 reset = 1'b1;
      #1 chk_reset_state("t6");
      @(negedge clk);
      chk_reset_state("t6_hold");
      reset = 1'b0;

      run_vecs(21, 24);
      send_bit(1'b0, 1'b0);
      chk("wv_one_cycle", 24, {7'd0, bus.word_valid}, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
